// File: rtl/trap_sequencer.sv
// rtl/trap_sequencer.sv - mapper trap arbiter and NMI sequencer
// Latches io/watchdog/ext trap sources, pulses nmi_n, and holds trap_state until supervisor exit.
module trap_sequencer #(
  parameter int NMI_WIDTH = 4,
  parameter int WDOG_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m1_n,
  input  logic              io_violation,
  input  logic              ext_nmi_req,
  input  logic              virtual_enable,
  input  logic              trap_exit,
  input  logic              wdog_load,
  input  logic [WDOG_W-1:0] wdog_value,
  output logic              nmi_n,
  output logic              trap_state,
  output logic              capture_addr,
  output logic [1:0]        cause,
  output logic              busy
);

  localparam int NW = $clog2(NMI_WIDTH + 1);

  typedef enum logic [2:0] {IDLE, CAPTURE, ASSERT, WAIT_ACK, TRAP} state_t;

  state_t            state;
  logic [NW-1:0]     nmi_cnt;
  logic [1:0]        cause_next;
  logic              m1_s1, m1_s2, m1_s3;
  logic              ext_prev;
  logic              m1_fall, ext_rise;
  logic [WDOG_W-1:0] wd_cnt;
  logic              wd_dec, wd_expire;
  logic              p_io, p_wd, p_ext;
  logic              sel_io, sel_wd, sel_ext;

  // m1_n is asynchronous to clk; the third flop only serves edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m1_s1    <= 1'b1;
      m1_s2    <= 1'b1;
      m1_s3    <= 1'b1;
      ext_prev <= 1'b0;
    end else begin
      m1_s1    <= m1_n;
      m1_s2    <= m1_s1;
      m1_s3    <= m1_s2;
      ext_prev <= ext_nmi_req;
    end
  end

  assign m1_fall  = m1_s3 & ~m1_s2;
  assign ext_rise = ext_nmi_req & ~ext_prev;

  assign wd_dec    = m1_fall && virtual_enable && !trap_state && (wd_cnt != '0);
  assign wd_expire = !wdog_load && wd_dec && (wd_cnt == WDOG_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (wdog_load) begin
      wd_cnt <= wdog_value;
    end else if (wd_dec) begin
      wd_cnt <= wd_cnt - WDOG_W'(1);
    end
  end

  assign sel_io  = (state == IDLE) && virtual_enable && p_io;
  assign sel_wd  = (state == IDLE) && virtual_enable && !p_io && p_wd;
  assign sel_ext = (state == IDLE) && virtual_enable && !p_io && !p_wd && p_ext;

  // A new request arriving on the clk its flag is served re-arms the flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_io  <= 1'b0;
      p_wd  <= 1'b0;
      p_ext <= 1'b0;
    end else if (!virtual_enable) begin
      p_io  <= 1'b0;
      p_wd  <= 1'b0;
      p_ext <= 1'b0;
    end else begin
      p_io  <= io_violation | (p_io & ~sel_io);
      p_wd  <= wd_expire | (p_wd & ~sel_wd);
      p_ext <= ext_rise | (p_ext & ~sel_ext);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      nmi_n        <= 1'b1;
      trap_state   <= 1'b0;
      capture_addr <= 1'b0;
      cause        <= 2'b00;
      cause_next   <= 2'b00;
      busy         <= 1'b0;
      nmi_cnt      <= '0;
    end else begin
      capture_addr <= 1'b0;
      if (!virtual_enable) begin
        state      <= IDLE;
        nmi_n      <= 1'b1;
        trap_state <= 1'b0;
        cause      <= 2'b00;
        busy       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (sel_io || sel_wd || sel_ext) begin
              state        <= CAPTURE;
              capture_addr <= 1'b1;
              busy         <= 1'b1;
              cause_next   <= sel_io ? 2'b01 : (sel_wd ? 2'b10 : 2'b11);
            end
          end
          CAPTURE: begin
            state   <= ASSERT;
            nmi_n   <= 1'b0;
            nmi_cnt <= NW'(NMI_WIDTH);
          end
          ASSERT: begin
            nmi_cnt <= nmi_cnt - NW'(1);
            if (nmi_cnt == NW'(1)) begin
              state <= WAIT_ACK;
              nmi_n <= 1'b1;
            end
          end
          WAIT_ACK: begin
            if (m1_fall) begin
              state      <= TRAP;
              trap_state <= 1'b1;
              cause      <= cause_next;
            end
          end
          TRAP: begin
            if (trap_exit) begin
              state      <= IDLE;
              trap_state <= 1'b0;
              cause      <= 2'b00;
              busy       <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
